// File: rtl/flag_ctrl_pkg.sv
// Shared types and sizing for the flag controller.
// FLAG_NEST_EN selects a 4-deep shadow stack; otherwise a single shadow entry.
package flag_ctrl_pkg;

`ifdef FLAG_NEST_EN
    localparam int unsigned SHAD_DEPTH = 4;
`else
    localparam int unsigned SHAD_DEPTH = 1;
`endif

    localparam int unsigned DEPTH_W = 3;

    typedef enum logic {
        NORMAL = 1'b0,
        ISR    = 1'b1
    } state_t;

    typedef struct packed {
        logic c;
        logic z;
        logic i;
    } flag_t;

endpackage

// File: rtl/flag_shadow_stack.sv
// LIFO of saved flag sets; SHAD_DEPTH entries (4 with FLAG_NEST_EN, else 1).
// dout always presents the most recently pushed entry.
module flag_shadow_stack
    import flag_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  flag_t              din,
    output flag_t              dout,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    generate
        if (SHAD_DEPTH == 1) begin : g_single
            flag_t entry_q;
            logic  valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_q <= '0;
                    valid_q <= 1'b0;
                end else if (push && !valid_q) begin
                    entry_q <= din;
                    valid_q <= 1'b1;
                end else if (pop && valid_q) begin
                    valid_q <= 1'b0;
                end
            end

            // Upper depth bits are structurally zero in the single-entry build.
            assign depth = DEPTH_W'(valid_q);
            assign dout  = entry_q;
            assign full  = valid_q;
            assign empty = !valid_q;
        end else begin : g_multi
            localparam int unsigned IDX_W = $clog2(SHAD_DEPTH);

            flag_t              mem_q [SHAD_DEPTH];
            logic [DEPTH_W-1:0] cnt_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned k = 0; k < SHAD_DEPTH; k++) begin
                        mem_q[IDX_W'(k)] <= '0;
                    end
                    cnt_q <= '0;
                end else if (push && !full) begin
                    mem_q[IDX_W'(cnt_q)] <= din;
                    cnt_q                <= cnt_q + DEPTH_W'(1);
                end else if (pop && !empty) begin
                    cnt_q <= cnt_q - DEPTH_W'(1);
                end
            end

            assign depth = cnt_q;
            assign dout  = mem_q[IDX_W'(cnt_q - DEPTH_W'(1))];
            assign full  = (cnt_q == DEPTH_W'(SHAD_DEPTH));
            assign empty = (cnt_q == '0);
        end
    endgenerate

endmodule

// File: rtl/flag_ctrl.sv
// Architectural C/Z/I flags with interrupt save/restore through a shadow stack.
// Nesting depth is 4 when FLAG_NEST_EN is defined, otherwise 1.
module flag_ctrl
    import flag_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_c,
    input  logic               alu_z,
    input  logic               c_ld,
    input  logic               z_ld,
    input  logic               c_set,
    input  logic               c_clr,
    input  logic               i_set,
    input  logic               i_clr,
    input  logic               int_ack,
    input  logic               reti,
    input  logic               reti_ie,
    output logic               c_flag,
    output logic               z_flag,
    output logic               i_flag,
    output logic               in_isr,
    output logic [DEPTH_W-1:0] depth,
    output logic               nest_err
);

    state_t state_q, state_d;
    flag_t  flags_q, flags_d;
    logic   err_q, err_d;

    logic   push, pop;
    flag_t  shadow_top;
    logic   shadow_full, shadow_empty;
    logic   unused_shadow_i;

    flag_shadow_stack u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (flags_q),
        .dout  (shadow_top),
        .depth (depth),
        .full  (shadow_full),
        .empty (shadow_empty)
    );

    // The saved I bit is kept for completeness; reti sets I from reti_ie.
    assign unused_shadow_i = shadow_top.i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= NORMAL;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

    // One action per cycle: reti > int_ack > flag set/clr/load.
    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;

        if (reti) begin
            if (!shadow_empty) begin
                pop       = 1'b1;
                flags_d.c = shadow_top.c;
                flags_d.z = shadow_top.z;
                flags_d.i = reti_ie;
                if (depth == DEPTH_W'(1)) begin
                    state_d = NORMAL;
                end
            end else begin
                err_d = 1'b1;
            end
        end else if (int_ack) begin
            flags_d.i = 1'b0;
            if (!shadow_full) begin
                push    = 1'b1;
                state_d = ISR;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            if (c_set) begin
                flags_d.c = 1'b1;
            end else if (c_clr) begin
                flags_d.c = 1'b0;
            end else if (c_ld) begin
                flags_d.c = alu_c;
            end

            if (z_ld) begin
                flags_d.z = alu_z;
            end

            if (i_set) begin
                flags_d.i = 1'b1;
            end else if (i_clr) begin
                flags_d.i = 1'b0;
            end
        end
    end

    assign c_flag   = flags_q.c;
    assign z_flag   = flags_q.z;
    assign i_flag   = flags_q.i;
    assign nest_err = err_q;
    assign in_isr   = (state_q == ISR);

endmodule
